// File: rtl/coef_bank.sv
// coef_bank: double-buffered, symmetric-folded FIR coefficient store.
// The active bank answers the filter's read port with a one-cycle registered read.
// The shadow bank is refilled over a valid/ready port.
// The banks swap in a single cycle once every unique tap has arrived.
module coef_bank #(
    parameter int NTAPS = 65,
    parameter int DW = 18,
    parameter int AW = 7,
    localparam int NSTORE = (NTAPS + 1) / 2,
    localparam int GW = DW + 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] coefaddress,
    output logic [DW-1:0] coefdata,
    input  logic          ld_start,
    input  logic          ld_abort,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic [GW-1:0] gain
);

    localparam int CW = $clog2(NSTORE);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SWAP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] count;
    logic [GW-1:0] acc;
    logic          bank_sel;  // 0: bank0 active, bank1 shadow
    logic [DW-1:0] bank0 [NSTORE];
    logic [DW-1:0] bank1 [NSTORE];

    logic          accept;
    logic          last_word;
    logic [GW-1:0] ld_ext;
    logic [GW-1:0] addend;

    logic [CW-1:0] rd_idx;
    logic          rd_zero;
    logic          rd_sel;
    logic [DW-1:0] rd_val;

    assign ld_ready = (state == LOAD);
    assign ld_busy  = (state != IDLE);
    assign ld_done  = (state == SWAP);

    // Abort wins over a same-cycle word, so an aborted word never lands.
    assign accept    = (state == LOAD) && ld_valid && !ld_abort;
    assign last_word = (count == CW'(NSTORE - 1));
    assign ld_ext    = {{(GW - DW){ld_data[DW-1]}}, ld_data};
    // Every stored tap except the centre one appears twice in the full response.
    assign addend    = last_word ? ld_ext : (ld_ext << 1);

    // Fold the tap address onto the stored half and flag out-of-range addresses.
    always_comb begin
        rd_idx  = '0;
        rd_zero = 1'b1;
        if (int'(coefaddress) < NSTORE) begin
            rd_idx  = CW'(coefaddress);
            rd_zero = 1'b0;
        end else if (int'(coefaddress) < NTAPS) begin
            rd_idx  = CW'(NTAPS - 1 - int'(coefaddress));
            rd_zero = 1'b0;
        end
    end

    // On the swap edge the select bit has not toggled yet, so look ahead.
    // This makes the read sampled on that edge see the new taps.
    assign rd_sel = bank_sel ^ (state == SWAP);
    assign rd_val = rd_sel ? bank1[rd_idx] : bank0[rd_idx];

    // Registered read port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coefdata <= '0;
        end else begin
            coefdata <= rd_zero ? '0 : rd_val;
        end
    end

    // Load FSM next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ld_start) state_next = LOAD;
            LOAD: begin
                if (ld_abort) begin
                    state_next = IDLE;
                end else if (accept && last_word) begin
                    state_next = SWAP;
                end
            end
            SWAP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state, load counter, gain accumulator, bank select and published gain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            bank_sel <= 1'b0;
            gain     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && ld_start) begin
                count <= '0;
                acc   <= '0;
            end
            if (accept) begin
                count <= count + CW'(1);
                acc   <= acc + addend;
            end
            if (state == SWAP) begin
                bank_sel <= ~bank_sel;
                gain     <= acc;
            end
        end
    end

    // Accepted words go to whichever bank is currently the shadow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSTORE; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (accept) begin
            if (bank_sel) begin
                bank0[count] <= ld_data;
            end else begin
                bank1[count] <= ld_data;
            end
        end
    end

endmodule
